seq_mult_unit: RTL and testbench

//  Iterative shift-add multiplier with valid/ready handshakes. Supports signed and unsigned operation.

---
 rtl/seq_mult_unit.sv | 130 +++++++++++++
 tb/tb_seq_mult_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier with operand/result handshakes.
// It retires BITS_PER_CYCLE multiplier bits per RUN cycle, so a product takes
// WIDTH/BITS_PER_CYCLE cycles. Signed operands are converted to magnitudes and
// a sign flag on entry, and the sign is applied once to the finished product.
module seq_mult_unit #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]     b_mag_q;
  logic                 sign_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 out_valid_q;
  logic                 in_ready_q;
  logic                 busy_q;

  logic [2*WIDTH-1:0]   partial_d;
  logic [2*WIDTH-1:0]   acc_d;

  // Magnitude of an operand; the most-negative value maps to 2^(W-1), which
  // still fits in W unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    magnitude = (is_signed && v[WIDTH-1]) ? (WIDTH'(0) - v) : v;
  endfunction

  // Two's-complement negation of the product when the sign flag is set.
  // Negating zero yields zero, so a zero operand never produces a -0 artefact.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic               neg);
    apply_sign = neg ? ((2*WIDTH)'(0) - mag) : mag;
  endfunction

  // Partial product for the low multiplier bits, built from shifted adds of
  // the already-aligned multiplicand.
  always_comb begin
    partial_d = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_mag_q[j]) begin
        partial_d = partial_d + (a_sh_q << j);
      end
    end
    acc_d = acc_q + partial_d;
  end

  // Control FSM and datapath registers; the last RUN cycle writes the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= (2*WIDTH)'(magnitude(a, op_signed));
            b_mag_q    <= magnitude(b, op_signed);
            sign_q     <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q      <= '0;
            cnt_q      <= CNT_W'(ITER);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_q << BITS_PER_CYCLE;
          b_mag_q <= b_mag_q >> BITS_PER_CYCLE;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= apply_sign(acc_d, sign_q);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises only after the result is taken, so the next
          // accept is at least one cycle later.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: directed and randomized checks of seq_mult_unit against a
// plain-arithmetic product model, with three radix variants side by side.
module tb_seq_mult_unit;

  localparam int W = 8;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            op_signed;
  logic            out_ready;

  logic            in_ready1, out_valid1, busy1;
  logic [2*W-1:0]  result1;
  logic            in_ready2, out_valid2, busy2;
  logic [2*W-1:0]  result2;
  logic            in_ready4, out_valid4, busy4;
  logic [2*W-1:0]  result4;

  int n_cmp;
  int n_bad;

  seq_mult_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op_signed(op_signed), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .busy(busy1)
  );

  seq_mult_unit #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op_signed(op_signed), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .busy(busy2)
  );

  seq_mult_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op_signed(op_signed), .out_valid(out_valid4),
    .out_ready(out_ready), .result(result4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Golden product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         s);
    int xi, yi, p;
    xi = s ? int'($signed(x)) : int'(x);
    yi = s ? int'($signed(y)) : int'(y);
    p  = xi * yi;
    return p[2*W-1:0];
  endfunction

  // One complete transaction on the radix-1 unit, with latency check.
  task automatic do_op(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic s,
                       input logic [2*W-1:0] exp);
    int n;
    n = 0;
    while (!in_ready1 && n < 50) begin step(); n++; end
    a = x; b = y; op_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid1 && n < 50) begin step(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk(tag, 32'(result1), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat1, lat2, lat4;
    int n, ops, cyc;
    logic [2*W-1:0] q_exp[$];
    logic [2*W-1:0] e;

    n_cmp = 0; n_bad = 0;
    in_valid = 1'b0; a = '0; b = '0; op_signed = 1'b0; out_ready = 1'b0;

    // Reset state
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    chk("rst_result", 32'(result1), 32'd0);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);

    // 255*255 on all three radices, latency 8/4/2
    a = 8'd255; b = 8'd255; op_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("run_busy", 32'(busy1), 32'd1);
    chk("run_in_ready", 32'(in_ready1), 32'd0);
    lat1 = -1; lat2 = -1; lat4 = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (out_valid1 && lat1 < 0) lat1 = i;
      if (out_valid2 && lat2 < 0) lat2 = i;
      if (out_valid4 && lat4 < 0) lat4 = i;
    end
    chk("lat_bpc1", 32'(lat1), 32'd8);
    chk("lat_bpc2", 32'(lat2), 32'd4);
    chk("lat_bpc4", 32'(lat4), 32'd2);
    chk("ff_bpc1", 32'(result1), 32'hFE01);
    chk("ff_bpc2", 32'(result2), 32'hFE01);
    chk("ff_bpc4", 32'(result4), 32'hFE01);
    chk("done_busy", 32'(busy1), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_keep_result", 32'(result1), 32'hFE01);

    // Signed corner cases
    do_op("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
    do_op("s_m128_1", 8'h80, 8'h01, 1'b1, 16'hFF80);
    do_op("s_0_m5", 8'h00, 8'hFB, 1'b1, 16'h0000);
    do_op("s_m3_7", 8'hFD, 8'h07, 1'b1, 16'hFFEB);

    // Backpressure: result held, new operands ignored
    a = 8'd10; b = 8'd11; op_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid1 && n < 50) begin step(); n++; end
    a = 8'd3; b = 8'd4; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(out_valid1), 32'd1);
      chk("bp_result", 32'(result1), 32'd110);
      chk("bp_in_ready", 32'(in_ready1), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready1), 32'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid1 && n < 50) begin step(); n++; end
    chk("bp_next", 32'(result1), 32'd12);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in the 4th RUN cycle
    a = 8'd100; b = 8'd200; op_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_result", 32'(result1), 32'd0);
    chk("mid_rst_valid", 32'(out_valid1), 32'd0);
    chk("mid_rst_ready", 32'(in_ready1), 32'd1);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    do_op("after_rst", 8'd7, 8'd9, 1'b0, 16'd63);

    // Randomized mix with stalls; queue model tracks accepted operands
    ops = 0; cyc = 0;
    while (ops < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      op_signed = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      if (in_valid && in_ready1) q_exp.push_back(ref_prod(a, b, op_signed));
      if (out_valid1 && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("rnd_spurious", 32'(result1), 32'hFFFF_FFFF);
        end else begin
          e = q_exp.pop_front();
          chk("rnd_prod", 32'(result1), 32'(e));
        end
        ops++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_ops_done", 32'(ops), 32'd1000);
    chk("rnd_queue_left", 32'(q_exp.size()), 32'(busy1 || out_valid1 ? 1 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
